// File: rtl/mac_array_ws.sv
// Weight-stationary ROWS x COLS MAC array with a valid/ready handshake and constant latency ROWS+COLS.
// Define MAC_ARRAY_SAT_EN for saturating accumulation; without it every addition wraps modulo 2^AW.
module mac_array_ws #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      w_load,
    input  logic [$clog2(ROWS)-1:0]   w_row,
    input  logic [COLS*DW-1:0]        w_i,
    input  logic [$clog2(COLS+1)-1:0] cfg_cols,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLS*DW-1:0]        x_i,
    input  logic                      psum_en,
    input  logic [ROWS*AW-1:0]        psum_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROWS*AW-1:0]        result,
    output logic                      busy
);
    localparam int LAT = ROWS + COLS;
    localparam int XD  = ROWS + COLS - 1;  // input register, column skew and row-to-row hops
    localparam int DKD = (ROWS > 1) ? ROWS - 1 : 1;
    localparam int CW  = $clog2(COLS + 1);
    localparam logic [CW-1:0] COLS_C = CW'(COLS);

    logic               ce, xfer, w_wr;
    logic [CW-1:0]      cfg_n, cfg_q;
    logic [LAT:0]       vld_q;
    logic [XD-1:0]      old_q;
    logic [DW-1:0]      w_q     [ROWS][COLS];
    logic [DW-1:0]      w_old_q [ROWS][COLS];
    logic [COLS*DW-1:0] x_q     [XD];
    logic [ROWS*AW-1:0] ps_q    [LAT];
    logic [AW-1:0]      s_q     [ROWS][COLS];
    logic [AW-1:0]      s_d     [ROWS][COLS];
    logic [AW-1:0]      dk_q    [ROWS][DKD];
    logic [ROWS*AW-1:0] res_q, res_d;

    function automatic logic [AW-1:0] add_f(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = a + b;
`ifdef MAC_ARRAY_SAT_EN
        if (a[AW-1] == b[AW-1] && s[AW-1] != a[AW-1])
            s = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`endif
        return s;
    endfunction

    always_comb begin
        ce       = !(vld_q[LAT] && !out_ready);
        in_ready = ce && !RST;
        xfer     = in_valid && in_ready;
        busy     = |vld_q;
        w_wr     = w_load && !busy;
        cfg_n    = (cfg_cols == '0 || cfg_cols > COLS_C) ? COLS_C : cfg_cols;
    end

    assign out_valid = vld_q[LAT];
    assign result    = res_q;

    // A vector accepted in the same cycle as a weight write is tagged (old_q) and reads the
    // pre-write snapshot; both banks are frozen while anything is in flight.
    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            vld_q   <= '0;
            old_q   <= '0;
            cfg_q   <= COLS_C;
            res_q   <= '0;
            w_q     <= '{default: '0};
            w_old_q <= '{default: '0};
        end else begin
            if (!busy) begin
                w_old_q <= w_q;
                if (w_load) begin
                    for (int c = 0; c < COLS; c++)
                        w_q[w_row][c] <= w_i[(COLS-1-c)*DW +: DW];
                end
                if (!xfer) cfg_q <= cfg_n;
            end
            if (ce) begin
                vld_q <= {vld_q[LAT-1:0], xfer};
                old_q <= {old_q[XD-2:0], w_wr};
                if (vld_q[LAT-1]) res_q <= res_d;
            end
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits decide what is meaningful.
    always_ff @(posedge CLK) begin
        if (xfer) begin
            x_q[0]  <= x_i;
            ps_q[0] <= psum_en ? psum_i : '0;
        end
        if (ce) begin
            for (int d = 1; d < XD; d++)  x_q[d]  <= x_q[d-1];
            for (int d = 1; d < LAT; d++) ps_q[d] <= ps_q[d-1];
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) s_q[r][c] <= s_d[r][c];
                dk_q[r][0] <= s_q[r][COLS-1];
                for (int j = 1; j < DKD; j++) dk_q[r][j] <= dk_q[r][j-1];
            end
        end
    end

    // PE (r,c) sees column c's activation after r+c stages; inactive columns add zero,
    // which delays the tap after column C-1 by COLS-C cycles.
    always_comb begin
        logic [DW-1:0]         wv, xv;
        logic signed [2*DW:0]  prod;
        logic [AW-1:0]         term, base;
        // NOTE: defaults first so no path through the block leaves a variable unassigned.
        wv   = '0;
        xv   = '0;
        prod = '0;
        term = '0;
        base = '0;
        s_d  = '{default: '0};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                wv   = old_q[r+c] ? w_old_q[r][c] : w_q[r][c];
                xv   = x_q[r+c][(COLS-1-c)*DW +: DW];
                prod = $signed(wv) * $signed({1'b0, xv});
                term = (CW'(c) < cfg_q) ? {{(AW-2*DW-1){prod[2*DW]}}, prod} : '0;
                base = (c == 0) ? '0 : s_q[r][(c > 0) ? c - 1 : 0];
                s_d[r][c] = add_f(base, term);
            end
        end
    end

    always_comb begin
        logic [AW-1:0] tap;
        tap   = '0;
        res_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r == ROWS - 1) tap = s_q[r][COLS-1];
            else               tap = dk_q[r][(r < ROWS - 1) ? ROWS - 2 - r : 0];
            res_d[(ROWS-1-r)*AW +: AW] = add_f(tap, ps_q[LAT-1][(ROWS-1-r)*AW +: AW]);
        end
    end
endmodule

// File: tb/tb_mac_array_ws.sv
// Scoreboard bench for mac_array_ws: the driver queues hand-computed results at accept,
// a negedge monitor pops and compares them (and the latency) at each output handshake.
module tb_mac_array_ws;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int LAT  = ROWS + COLS;
    localparam int RV   = ROWS * AW;
`ifdef MAC_ARRAY_SAT_EN
    localparam logic [31:0] SAT_ROW0 = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SAT_ROW0 = 32'h8000_3EF1;
`endif

    logic                      CLK;
    logic                      RST;
    logic                      w_load;
    logic [$clog2(ROWS)-1:0]   w_row;
    logic [COLS*DW-1:0]        w_i;
    logic [$clog2(COLS+1)-1:0] cfg_cols;
    logic                      in_valid;
    logic                      in_ready;
    logic [COLS*DW-1:0]        x_i;
    logic                      psum_en;
    logic [RV-1:0]             psum_i;
    logic                      out_valid;
    logic                      out_ready;
    logic [RV-1:0]             result;
    logic                      busy;

    typedef struct {
        logic [RV-1:0] res;
        time           t;
        bit            lat;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [RV-1:0] cur_exp;
    bit            cur_lat;

    mac_array_ws #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .w_load(w_load), .w_row(w_row), .w_i(w_i),
        .cfg_cols(cfg_cols), .in_valid(in_valid), .in_ready(in_ready), .x_i(x_i),
        .psum_en(psum_en), .psum_i(psum_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [RV-1:0] act, input logic [RV-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", result);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                if (e.lat) check("latency", RV'(($time - e.t - 5) / 10), RV'(LAT));
            end
        end
    end

    // One clock: inputs already driven, sample in_ready mid-cycle, record accept at the edge.
    task automatic step(output bit acc);
        @(negedge CLK);
        acc = in_valid && in_ready;
        if (in_valid && out_valid && !out_ready) check("in_ready_stall", RV'(in_ready), RV'(0));
        @(posedge CLK);
        if (acc) sb.push_back('{res: cur_exp, t: $time, lat: cur_lat});
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    task automatic send(input logic [COLS*DW-1:0] x, input logic pen, input logic [RV-1:0] ps,
                        input logic [RV-1:0] ex, input bit lat);
        bit a;
        int tries;
        in_valid = 1'b1;
        x_i      = x;
        psum_en  = pen;
        psum_i   = ps;
        cur_exp  = ex;
        cur_lat  = lat;
        a        = 1'b0;
        tries    = 0;
        while (!a && tries < 50) begin
            step(a);
            tries++;
        end
        check("accept", RV'(a), RV'(1));
        in_valid = 1'b0;
    endtask

    task automatic load_row(input int r, input logic [COLS*DW-1:0] w);
        bit a;
        w_load = 1'b1;
        w_row  = r[$clog2(ROWS)-1:0];
        w_i    = w;
        step(a);
        w_load = 1'b0;
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            step(a);
            n++;
        end
        check("drain_busy", RV'(busy), RV'(0));
        check("drain_pending", RV'(sb.size()), RV'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n, i;
        bit            a;
        logic [31:0]   wrow;
        RST = 1'b1; w_load = 1'b0; w_row = '0; w_i = '0; cfg_cols = 3'd4;
        in_valid = 1'b0; x_i = '0; psum_en = 1'b0; psum_i = '0; out_ready = 1'b1;
        cur_exp = '0; cur_lat = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", RV'(in_ready), RV'(0));
        check("rst_out_valid", RV'(out_valid), RV'(0));
        check("rst_busy", RV'(busy), RV'(0));
        check("rst_result", result, RV'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("in_ready_after_rst", RV'(in_ready), RV'(1));
        @(posedge CLK); #1;

        // Weights are zero after reset, so only the injected partial sums come through.
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b1, {32'd5, 32'd6, 32'd7, 32'd8},
             {32'd5, 32'd6, 32'd7, 32'd8}, 1'b1);
        drain();

        // Identity weights.
        for (int r = 0; r < ROWS; r++) begin
            wrow = 32'h0000_0001 << ((COLS - 1 - r) * DW);
            load_row(r, wrow);
        end
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, '0, {32'd1, 32'd2, 32'd3, 32'd4}, 1'b1);
        drain();

        // Signed weights against full-scale unsigned activations.
        load_row(0, {4{8'hFF}});
        send({4{8'd255}}, 1'b0, '0, {32'hFFFF_FC04, 32'd255, 32'd255, 32'd255}, 1'b1);
        drain();

        // Column settings: 2 active columns, then 0 meaning all columns.
        for (int r = 0; r < ROWS; r++) load_row(r, {4{8'd1}});
        cfg_cols = 3'd2;
        idle(1);
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, '0, {4{32'd3}}, 1'b1);
        drain();
        cfg_cols = 3'd0;
        idle(1);
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, '0, {4{32'd10}}, 1'b1);
        drain();
        cfg_cols = 3'd4;
        idle(1);

        // Back-to-back stream of 12 with a 5-cycle output stall mid-stream.
        n = 1;
        i = 0;
        while (n <= 12 && i < 80) begin
            out_ready = !(i >= 9 && i < 14);
            in_valid  = 1'b1;
            x_i       = {8'(n), 24'd0};
            psum_en   = 1'b0;
            cur_exp   = {4{32'(n)}};
            cur_lat   = 1'b0;
            step(a);
            if (a) n++;
            i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", RV'(n), RV'(13));
        drain();

        // A weight write while busy must be ignored; then psum injection.
        send({4{8'd1}}, 1'b0, '0, {4{32'd4}}, 1'b0);
        w_load = 1'b1; w_row = '0; w_i = {4{8'd5}};
        step(a);
        w_load = 1'b0;
        check("busy_during_load", RV'(busy), RV'(1));
        drain();
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b1, {32'd0, 32'd100, 32'd200, 32'd300},
             {32'd10, 32'd110, 32'd210, 32'd310}, 1'b1);
        drain();

        // Weight write in the accept cycle: that vector uses old weights, the next one new.
        w_load = 1'b1; w_row = '0; w_i = {4{8'd2}};
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, '0, {4{32'd10}}, 1'b1);
        w_load = 1'b0;
        send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, '0, {32'd20, 32'd10, 32'd10, 32'd10}, 1'b1);
        drain();

        // Accumulation overflow: 0x7FFFFFF0 + 127*127.
        load_row(0, {8'd127, 24'd0});
        cfg_cols = 3'd1;
        idle(1);
        send({8'd127, 24'd0}, 1'b1, {32'h7FFF_FFF0, 96'd0},
             {SAT_ROW0, 32'd127, 32'd127, 32'd127}, 1'b1);
        drain();

        // Reset with a vector in flight: it must never be delivered.
        cfg_cols = 3'd4;
        idle(1);
        send({4{8'd1}}, 1'b0, '0, '0, 1'b0);
        idle(2);
        RST = 1'b1;
        sb.delete();
        idle(2);
        RST = 1'b0;
        check("midrst_busy", RV'(busy), RV'(0));
        check("midrst_out_valid", RV'(out_valid), RV'(0));
        idle(LAT + 4);
        check("midrst_quiet", RV'(out_valid), RV'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
